serial_2wire_arbiter: RTL and testbench

Round-robin arbiter that shares one `serial_2wire` bus master between `NUM_REQ` requesters, for example the OLED display driver and a sensor reader on the same two-wire bus. Each grant covers one whole bus transaction. The owner keeps the bus from its first enable until it drops enable and the master reports ready. The block sits between the requesters and the `serial_2wire` instance. It multiplexes the owner's request signals onto the master and routes the master's status back to the owner only.

---
 rtl/serial_arb_pkg.sv | 16 +
 rtl/arb_rr_pick.sv | 29 ++
 rtl/serial_2wire_arbiter.sv | 150 +++++++++++++++
 tb/tb_serial_2wire_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arb_pkg.sv
// Shared types and helpers for the serial_2wire round-robin arbiter.
package serial_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } t_arb_state;

    // Next round-robin start index after idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, with wrap-around.
module arb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            int cand;
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand]) begin
                idx   = IW'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_2wire_arbiter.sv
// Shares one serial_2wire master between NUM_REQ requesters, one whole
// transaction per grant, round-robin between transactions.
module serial_2wire_arbiter
    import serial_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int BITS          = 8,
    parameter int ADDR_BITS     = 8,
    parameter int DRAIN_TIMEOUT = 1_000_000,
    parameter int IDX_BITS      = $clog2(NUM_REQ)
) (
    input  logic                               in_clk,
    input  logic                               in_rst,
    input  logic [NUM_REQ-1:0]                 in_req_enable,
    input  logic [NUM_REQ-1:0]                 in_req_write,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]  in_req_addr_write,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]  in_req_addr_read,
    input  logic [NUM_REQ-1:0][BITS-1:0]       in_req_data,
    output logic [NUM_REQ-1:0]                 out_req_grant,
    output logic [NUM_REQ-1:0]                 out_req_ready,
    output logic [NUM_REQ-1:0]                 out_req_next_word,
    output logic [NUM_REQ-1:0]                 out_req_err,
    output logic [BITS-1:0]                    out_req_data,
    output logic                               out_ser_enable,
    output logic                               out_ser_write,
    output logic [ADDR_BITS-1:0]               out_ser_addr_write,
    output logic [ADDR_BITS-1:0]               out_ser_addr_read,
    output logic [BITS-1:0]                    out_ser_data,
    input  logic                               in_ser_ready,
    input  logic                               in_ser_err,
    input  logic                               in_ser_next_word,
    input  logic [BITS-1:0]                    in_ser_data,
    output logic [IDX_BITS-1:0]                out_owner,
    output logic                               out_busy,
    output logic                               out_timeout,
    output t_arb_state                         out_state
);

    localparam int CNT_W = $clog2(DRAIN_TIMEOUT) + 1;

    t_arb_state          state;
    logic [IDX_BITS-1:0] owner;
    logic [IDX_BITS-1:0] rr_ptr;
    logic [IDX_BITS-1:0] pick_idx;
    logic                pick_valid;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  err;
    logic [CNT_W-1:0]    drain_cnt;
    logic                timeout;
    logic                busy;
    logic                owner_en;
    logic                active;
    logic                routed;

    arb_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_BITS)
    ) u_pick (
        .req   (in_req_enable),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_en = in_req_enable[owner];
    assign active   = (state == ST_ACTIVE);
    assign routed   = (state == ST_ACTIVE) || (state == ST_DRAIN);

    // Zero-latency mux: requesters may update data in the next_word cycle.
    always_comb begin
        out_ser_enable     = 1'b0;
        out_ser_write      = 1'b0;
        out_ser_addr_write = '0;
        out_ser_addr_read  = '0;
        out_ser_data       = '0;
        out_req_ready      = '0;
        out_req_next_word  = '0;
        if (active) begin
            out_ser_enable     = owner_en;
            out_ser_write      = in_req_write[owner];
            out_ser_addr_write = in_req_addr_write[owner];
            out_ser_addr_read  = in_req_addr_read[owner];
            out_ser_data       = in_req_data[owner];
        end
        if (routed) begin
            out_req_ready[owner]     = in_ser_ready;
            out_req_next_word[owner] = in_ser_next_word;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            err       <= '0;
            drain_cnt <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_ser_ready && pick_valid) begin
                        owner <= pick_idx;
                        grant <= NUM_REQ'(1) << pick_idx;
                        busy  <= 1'b1;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    drain_cnt <= '0;
                    state     <= owner_en ? ST_ACTIVE : ST_DRAIN;
                end
                ST_ACTIVE: begin
                    if (in_ser_err) begin
                        err[owner] <= 1'b1;
                    end
                    if (!owner_en) begin
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (in_ser_ready || (drain_cnt == CNT_W'(DRAIN_TIMEOUT - 1))) begin
                        timeout <= !in_ser_ready;
                        grant   <= '0;
                        err     <= '0;
                        busy    <= 1'b0;
                        rr_ptr  <= IDX_BITS'(rr_next(int'(owner), NUM_REQ));
                        state   <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_req_grant = grant;
    assign out_req_err   = err;
    assign out_req_data  = in_ser_data;
    assign out_owner     = owner;
    assign out_busy      = busy;
    assign out_timeout   = timeout;
    assign out_state     = state;

endmodule

// File: tb/tb_serial_2wire_arbiter.sv
// Directed bench for serial_2wire_arbiter with two requesters and a short drain timeout.
module tb_serial_2wire_arbiter;
    import serial_arb_pkg::*;

    localparam int N  = 2;
    localparam int B  = 8;
    localparam int A  = 8;
    localparam int T  = 8;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]        en, wr;
    logic [N-1:0][A-1:0] aw, ar;
    logic [N-1:0][B-1:0] dat;
    logic [N-1:0]        grant, rdy, nxt, err;
    logic [B-1:0]        rdata;
    logic                ser_en, ser_wr;
    logic [A-1:0]        ser_aw, ser_ar;
    logic [B-1:0]        ser_d;
    logic                ser_ready, ser_err, ser_next;
    logic [B-1:0]        ser_rdata;
    logic [IW-1:0]       owner;
    logic                busy, tmo;
    t_arb_state          st;

    int checks = 0;
    int errors = 0;

    serial_2wire_arbiter #(
        .NUM_REQ       (N),
        .BITS          (B),
        .ADDR_BITS     (A),
        .DRAIN_TIMEOUT (T),
        .IDX_BITS      (IW)
    ) dut (
        .in_clk             (clk),
        .in_rst             (rst),
        .in_req_enable      (en),
        .in_req_write       (wr),
        .in_req_addr_write  (aw),
        .in_req_addr_read   (ar),
        .in_req_data        (dat),
        .out_req_grant      (grant),
        .out_req_ready      (rdy),
        .out_req_next_word  (nxt),
        .out_req_err        (err),
        .out_req_data       (rdata),
        .out_ser_enable     (ser_en),
        .out_ser_write      (ser_wr),
        .out_ser_addr_write (ser_aw),
        .out_ser_addr_read  (ser_ar),
        .out_ser_data       (ser_d),
        .in_ser_ready       (ser_ready),
        .in_ser_err         (ser_err),
        .in_ser_next_word   (ser_next),
        .in_ser_data        (ser_rdata),
        .out_owner          (owner),
        .out_busy           (busy),
        .out_timeout        (tmo),
        .out_state          (st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        en = '0; wr = '0; aw = '0; ar = '0; dat = '0;
        ser_ready = 1'b1; ser_err = 1'b0; ser_next = 1'b0; ser_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ser_en", 32'(ser_en), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_state", 32'(st), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        // Single requester, three words, then late drop
        aw[0] = 8'h3C; ar[0] = 8'h3D; dat[0] = 8'hA1; wr[0] = 1'b1;
        aw[1] = 8'h50; ar[1] = 8'h51; dat[1] = 8'hEE; wr[1] = 1'b1;
        en[0] = 1'b1;
        tick();
        chk("b_state_grant", 32'(st), 32'(ST_GRANT));
        chk("b_grant", 32'(grant), 32'h1);
        chk("b_ser_en_grant", 32'(ser_en), 32'h0);
        chk("b_busy", 32'(busy), 32'h1);
        ser_ready = 1'b0;
        tick();
        chk("b_ser_en", 32'(ser_en), 32'h1);
        chk("b_ser_d0", 32'(ser_d), 32'hA1);
        chk("b_ser_aw", 32'(ser_aw), 32'h3C);
        chk("b_ser_ar", 32'(ser_ar), 32'h3D);
        chk("b_ser_wr", 32'(ser_wr), 32'h1);
        chk("b_rdy_low", 32'(rdy), 32'h0);
        ser_rdata = 8'h5A;
        #1;
        chk("b_rdata", 32'(rdata), 32'h5A);
        ser_next = 1'b1; dat[0] = 8'hB2;
        #1;
        chk("b_nxt1", 32'(nxt), 32'h1);
        chk("b_ser_d1", 32'(ser_d), 32'hB2);
        tick();
        ser_next = 1'b0;
        #1;
        chk("b_nxt_off", 32'(nxt), 32'h0);
        ser_next = 1'b1; dat[0] = 8'hC3;
        #1;
        chk("b_ser_d2", 32'(ser_d), 32'hC3);
        tick();
        ser_next = 1'b0;
        en[0] = 1'b0;
        tick();
        chk("b_state_drain", 32'(st), 32'(ST_DRAIN));
        chk("b_grant_drain", 32'(grant), 32'h1);
        chk("b_ser_en_drain", 32'(ser_en), 32'h0);
        tick();
        chk("b_still_drain", 32'(st), 32'(ST_DRAIN));
        ser_ready = 1'b1;
        #1;
        chk("b_rdy_owner", 32'(rdy), 32'h1);
        tick();
        chk("b_state_idle", 32'(st), 32'(ST_IDLE));
        chk("b_grant_idle", 32'(grant), 32'h0);
        chk("b_busy_idle", 32'(busy), 32'h0);

        // Error latched for owner 1 until drain exits
        wr[1] = 1'b0;
        en[1] = 1'b1;
        tick();
        chk("c_owner", 32'(owner), 32'h1);
        chk("c_grant", 32'(grant), 32'h2);
        ser_ready = 1'b0;
        tick();
        chk("c_ser_wr", 32'(ser_wr), 32'h0);
        chk("c_ser_aw", 32'(ser_aw), 32'h50);
        ser_err = 1'b1;
        tick();
        ser_err = 1'b0;
        chk("c_err_set", 32'(err), 32'h2);
        tick();
        chk("c_err_hold", 32'(err), 32'h2);
        en[1] = 1'b0;
        tick();
        chk("c_err_drain", 32'(err), 32'h2);
        ser_ready = 1'b1;
        tick();
        chk("c_err_clear", 32'(err), 32'h0);
        chk("c_state_idle", 32'(st), 32'(ST_IDLE));

        // Drain timeout, with error arriving in the same cycle as the drop
        en[0] = 1'b1;
        tick();
        chk("d_owner", 32'(owner), 32'h0);
        ser_ready = 1'b0;
        tick();
        en[0] = 1'b0; ser_err = 1'b1;
        tick();
        ser_err = 1'b0;
        chk("d_state_drain", 32'(st), 32'(ST_DRAIN));
        chk("d_err_drop", 32'(err), 32'h1);
        repeat (7) tick();
        chk("d_drain_8", 32'(st), 32'(ST_DRAIN));
        chk("d_tmo_early", 32'(tmo), 32'h0);
        chk("d_err_late", 32'(err), 32'h1);
        tick();
        chk("d_state_idle", 32'(st), 32'(ST_IDLE));
        chk("d_tmo_pulse", 32'(tmo), 32'h1);
        chk("d_err_clear", 32'(err), 32'h0);
        tick();
        chk("d_tmo_end", 32'(tmo), 32'h0);

        // Mid-operation reset
        ser_ready = 1'b1;
        en[1] = 1'b1;
        tick();
        chk("e_owner", 32'(owner), 32'h1);
        ser_ready = 1'b0;
        tick();
        chk("e_ser_en", 32'(ser_en), 32'h1);
        rst = 1'b1;
        #1;
        chk("e_rst_ser_en", 32'(ser_en), 32'h0);
        chk("e_rst_grant", 32'(grant), 32'h0);
        chk("e_rst_busy", 32'(busy), 32'h0);
        chk("e_rst_owner", 32'(owner), 32'h0);
        chk("e_rst_state", 32'(st), 32'(ST_IDLE));
        en[1] = 1'b0; ser_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Simultaneous requests: req0 first, then rotated pair serves req1 first
        en = 2'b11;
        tick();
        chk("f_owner0", 32'(owner), 32'h0);
        chk("f_grant0", 32'(grant), 32'h1);
        ser_ready = 1'b0;
        tick();
        ser_next = 1'b1;
        #1;
        chk("f_nxt_owner_only", 32'(nxt), 32'h1);
        ser_next = 1'b0;
        en[0] = 1'b0;
        tick();
        chk("f_drain0", 32'(st), 32'(ST_DRAIN));
        en[0] = 1'b1; ser_ready = 1'b1;
        tick();
        chk("f_idle_regrant", 32'(st), 32'(ST_IDLE));
        chk("f_grant_none", 32'(grant), 32'h0);
        tick();
        chk("f_owner1", 32'(owner), 32'h1);
        chk("f_grant1", 32'(grant), 32'h2);
        ser_ready = 1'b0;
        tick();
        chk("f_ser_aw1", 32'(ser_aw), 32'h50);
        en[1] = 1'b0;
        tick();
        ser_ready = 1'b1;
        tick();
        tick();
        chk("f_owner0_second", 32'(owner), 32'h0);
        chk("f_grant0_second", 32'(grant), 32'h1);
        en[0] = 1'b0;
        tick();
        chk("f_grant_to_drain", 32'(st), 32'(ST_DRAIN));
        tick();
        chk("f_final_idle", 32'(st), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
